// File: rtl/cmd_seq_pkg.sv
// rtl/cmd_seq_pkg.sv - opcodes, response codes, status and FSM types shared by cmd_sequencer
package cmd_seq_pkg;

    localparam logic [7:0] OP_REQ_BATT  = 8'h01;
    localparam logic [7:0] OP_SET_PTCH  = 8'h02;
    localparam logic [7:0] OP_SET_ROLL  = 8'h03;
    localparam logic [7:0] OP_SET_YAW   = 8'h04;
    localparam logic [7:0] OP_SET_THRST = 8'h05;
    localparam logic [7:0] OP_CALIBRATE = 8'h06;
    localparam logic [7:0] OP_EMER_LAND = 8'h07;
    localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

    localparam logic [7:0] ACK = 8'hA5;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_NAK     = 2'd1,
        ST_TIMEOUT = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        CHECK
    } state_e;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - DEPTH-entry {opcode, data} queue with registered full/empty and flush
module cmd_fifo
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       wr_en_i,
    input  cmd_entry_t wr_entry_i,
    input  logic       rd_en_i,
    output cmd_entry_t rd_entry_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic          do_wr, do_rd;

    // A flush restarts the queue at slot 0; a simultaneous write becomes the sole entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_idx   = wr_ptr_q;
        do_wr    = 1'b0;
        do_rd    = 1'b0;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_idx   = '0;
            do_wr    = wr_en_i;
            wr_ptr_d = AW'(wr_en_i);
            count_d  = CW'(wr_en_i);
        end else begin
            do_wr    = wr_en_i && !full_q;
            do_rd    = rd_en_i && !empty_q;
            wr_ptr_d = wr_ptr_q + AW'(do_wr);
            rd_ptr_d = rd_ptr_q + AW'(do_rd);
            count_d  = count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_idx] <= wr_entry_i;
        end
    end

    assign rd_entry_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - queues commands and issues them to CommMaster with timeout/retry
// CMD_SEQ_EMER_PRIO_EN: EMER_LAND push flushes pending entries and jumps the queue.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MAX_RETRY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_cmd,
    input  logic [15:0] push_data,
    input  logic        abort,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        snd_cmd,
    input  logic        frm_snt,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic        done,
    output logic [1:0]  status,
    output logic [7:0]  done_cmd,
    output logic [7:0]  batt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    resp_q, resp_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [15:0]   data_q, data_d;
    logic [7:0]    batt_q, batt_d;

    cmd_entry_t    push_entry, head_entry;
    logic          fifo_full, fifo_empty, fifo_pop, fifo_flush, emer_flush;
    logic          expired, can_retry;

`ifdef CMD_SEQ_EMER_PRIO_EN
    assign emer_flush = push && (push_cmd == OP_EMER_LAND);
`else
    assign emer_flush = 1'b0;
`endif

    assign push_entry = '{op: push_cmd, data: push_data};
    assign fifo_flush = abort || emer_flush;

    cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (fifo_flush),
        .wr_en_i    (push && !abort),
        .wr_entry_i (push_entry),
        .rd_en_i    (fifo_pop),
        .rd_entry_o (head_entry),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // The SEND cycle counts toward the window, so resends land exactly TIMEOUT_CYC apart.
    assign expired   = (timer_q == TW'(TIMEOUT_CYC - 2));
    assign can_retry = (retry_q < RW'(MAX_RETRY));

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        resp_d       = resp_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        batt_d       = batt_q;
        fifo_pop     = 1'b0;
        snd_cmd      = 1'b0;
        clr_resp_rdy = 1'b0;
        done         = 1'b0;
        status       = ST_OK;
        done_cmd     = '0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                fifo_pop = 1'b1;
                cmd_d    = head_entry.op;
                data_d   = head_entry.data;
                retry_d  = '0;
                tmo_d    = 1'b0;
                state_d  = SEND;
            end
            SEND: begin
                snd_cmd = 1'b1;
                timer_d = '0;
                state_d = WAIT_SNT;
            end
            WAIT_SNT, WAIT_RESP: begin
                timer_d = timer_q + TW'(1);
                if (state_q == WAIT_SNT && frm_snt) begin
                    state_d = WAIT_RESP;
                end else if (state_q == WAIT_RESP && resp_rdy) begin
                    resp_d  = resp;
                    state_d = CHECK;
                end else if (expired) begin
                    if (can_retry) begin
                        retry_d = retry_q + RW'(1);
                        state_d = SEND;
                    end else begin
                        tmo_d   = 1'b1;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                clr_resp_rdy = 1'b1;
                done         = 1'b1;
                done_cmd     = cmd_q;
                if (tmo_q) begin
                    status = ST_TIMEOUT;
                end else if (cmd_q == OP_REQ_BATT) begin
                    status = ST_OK;
                    batt_d = resp_q;
                end else if (resp_q == ACK) begin
                    status = ST_OK;
                end else begin
                    status = ST_NAK;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d      = IDLE;
            fifo_pop     = 1'b0;
            cmd_d        = cmd_q;
            data_d       = data_q;
            batt_d       = batt_q;
            snd_cmd      = 1'b0;
            done         = 1'b0;
            status       = ST_OK;
            done_cmd     = '0;
            clr_resp_rdy = resp_rdy;
        end

        if (rst) begin
            snd_cmd      = 1'b0;
            clr_resp_rdy = 1'b0;
            done         = 1'b0;
            status       = ST_OK;
            done_cmd     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= '0;
            tmo_q   <= 1'b0;
            resp_q  <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            batt_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            resp_q  <= resp_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            batt_q  <= batt_d;
        end
    end

    assign full  = fifo_full;
    assign empty = fifo_empty;
    assign busy  = (state_q != IDLE);
    assign cmd   = cmd_q;
    assign data  = data_q;
    assign batt  = batt_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb/tb_cmd_sequencer.sv - scoreboard bench for cmd_sequencer with a CommMaster/copter model
module tb_cmd_sequencer;
    import cmd_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 40;
    localparam int MAXR  = 2;

    logic        clk = 1'b0;
    logic        rst, push, abort, frm_snt, resp_rdy;
    logic [7:0]  push_cmd, resp;
    logic [15:0] push_data;
    logic        full, empty, busy, snd_cmd, clr_resp_rdy, done;
    logic [7:0]  cmd, done_cmd, batt;
    logic [15:0] data;
    logic [1:0]  status;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] data;
        logic [1:0]  st;
        int          ns;
        logic [7:0]  rsp;
    } sb_t;

    sb_t  sb[$];
    sb_t  de;
    int   checks = 0, errors = 0;
    int   cyc = 0, push_cyc = 0, last_snd = 0, send_cnt = 0, done_cnt = 0, dc = 0;
    bit   lat_chk = 0, batt_chk = 0, suppress = 0;
    logic [7:0] model_resp = 8'hA5;
    logic [7:0] batt_exp = 8'h00;

    cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_data(push_data),
        .abort(abort), .full(full), .empty(empty), .busy(busy), .cmd(cmd), .data(data),
        .snd_cmd(snd_cmd), .frm_snt(frm_snt), .resp_rdy(resp_rdy), .resp(resp),
        .clr_resp_rdy(clr_resp_rdy), .done(done), .status(status), .done_cmd(done_cmd),
        .batt(batt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_push(input logic [7:0] op, input logic [15:0] d, input bit track,
                           input logic [1:0] st, input int ns, input logic [7:0] r);
        sb_t e;
        @(negedge clk);
        push = 1'b1; push_cmd = op; push_data = d;
        if (track) begin
            e.op = op; e.data = d; e.st = st; e.ns = ns; e.rsp = r;
            sb.push_back(e);
        end
        @(negedge clk);
        push = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic wait_done(input int n, input int budget);
        int target;
        int k;
        target = done_cnt + n;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_done", done_cnt >= target, 1);
    endtask

    // CommMaster + copter: frame goes out 3 cycles after snd_cmd, reply 4 cycles later.
    initial begin
        int snt_dly, rsp_dly;
        frm_snt = 1'b0; resp_rdy = 1'b0; resp = '0; snt_dly = 0; rsp_dly = 0;
        forever begin
            @(posedge clk); #1;
            frm_snt = 1'b0;
            if (clr_resp_rdy) resp_rdy = 1'b0;
            if (snd_cmd) begin
                snt_dly = 3; rsp_dly = 0;
            end else if (snt_dly > 0) begin
                snt_dly--;
                if (snt_dly == 0) begin
                    frm_snt = 1'b1;
                    if (!suppress) rsp_dly = 4;
                end
            end else if (rsp_dly > 0) begin
                rsp_dly--;
                if (rsp_dly == 0) begin
                    resp_rdy = 1'b1;
                    resp = model_resp;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (batt_chk) begin
                check_eq("batt", batt, batt_exp);
                batt_chk = 0;
            end
            if (snd_cmd) begin
                check_eq("snd_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    check_eq("snd_cmd_op", cmd, sb[0].op);
                    check_eq("snd_data", data, sb[0].data);
                end
                send_cnt++;
                if (send_cnt > 1) check_eq("retry_gap", cyc - last_snd, TMO);
                last_snd = cyc;
                if (lat_chk) begin
                    check_eq("snd_latency", cyc - push_cyc, 2);
                    lat_chk = 0;
                end
            end
            if (done) begin
                check_eq("done_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    de = sb.pop_front();
                    check_eq("done_cmd", done_cmd, de.op);
                    check_eq("status", status, de.st);
                    check_eq("send_count", send_cnt, de.ns);
                    if (de.op == OP_REQ_BATT && de.st == ST_OK) batt_exp = de.rsp;
                end
                batt_chk = 1;
                send_cnt = 0;
                done_cnt++;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; push = 1'b0; push_cmd = '0; push_data = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_full", full, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd", cmd, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_snd", snd_cmd, 0);
        check_eq("rst_clr", clr_resp_rdy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_status", status, 0);
        check_eq("rst_done_cmd", done_cmd, 0);
        check_eq("rst_batt", batt, 0);
        rst = 1'b0;

        // battery request, first-command latency
        model_resp = 8'hC0;
        lat_chk = 1;
        do_push(OP_REQ_BATT, 16'h0000, 1, ST_OK, 1, 8'hC0);
        wait_done(1, 200);

        // two acked commands in order
        model_resp = 8'hA5;
        do_push(OP_SET_PTCH, 16'h003A, 1, ST_OK, 1, 8'hA5);
        do_push(OP_SET_THRST, 16'h00FD, 1, ST_OK, 1, 8'hA5);
        wait_done(2, 400);

        // NAK is not retried
        model_resp = 8'h5A;
        do_push(OP_SET_ROLL, 16'h0011, 1, ST_NAK, 1, 8'h5A);
        wait_done(1, 200);

        // timeout after MAX_RETRY resends
        model_resp = 8'hA5;
        suppress = 1;
        do_push(OP_SET_YAW, 16'h1234, 1, ST_TIMEOUT, MAXR + 1, 8'h00);
        wait_done(1, 400);
        suppress = 0;

        // fill behind a stalled command; fifth push is dropped
        suppress = 1;
        do_push(OP_MTRS_OFF, 16'h0001, 1, ST_TIMEOUT, MAXR + 1, 8'h00);
        do_push(OP_SET_PTCH, 16'h0100, 1, ST_OK, 1, 8'hA5);
        do_push(OP_SET_ROLL, 16'h0200, 1, ST_OK, 1, 8'hA5);
        do_push(OP_SET_YAW, 16'h0300, 1, ST_OK, 1, 8'hA5);
        check_eq("not_full_3", full, 0);
        do_push(OP_SET_THRST, 16'h0400, 1, ST_OK, 1, 8'hA5);
        check_eq("full_4", full, 1);
        do_push(OP_CALIBRATE, 16'hDEAD, 0, ST_OK, 1, 8'hA5);
        check_eq("full_after_drop", full, 1);
        wait_done(1, 400);
        suppress = 0;
        wait_done(4, 600);
        repeat (20) @(negedge clk);
        check_eq("drained_empty", empty, 1);
        check_eq("drained_sb", sb.size(), 0);

        // abort in WAIT_RESP with entries queued
        suppress = 1;
        do_push(OP_CALIBRATE, 16'hBEEF, 1, ST_OK, 1, 8'hA5);
        do_push(OP_SET_PTCH, 16'h0005, 0, ST_OK, 1, 8'hA5);
        do_push(OP_SET_ROLL, 16'h0006, 0, ST_OK, 1, 8'hA5);
        repeat (10) @(negedge clk);
        check_eq("pre_abort_busy", busy, 1);
        check_eq("pre_abort_empty", empty, 0);
        dc = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sb.delete();
        send_cnt = 0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_empty", empty, 1);
        check_eq("abort_full", full, 0);
        repeat (100) @(negedge clk);
        check_eq("abort_no_done", done_cnt, dc);
        check_eq("abort_idle", busy, 0);
        suppress = 0;

`ifdef CMD_SEQ_EMER_PRIO_EN
        model_resp = 8'hA5;
        do_push(OP_SET_THRST, 16'h0AAA, 1, ST_OK, 1, 8'hA5);
        do_push(OP_SET_PTCH, 16'h0BBB, 0, ST_OK, 1, 8'hA5);
        do_push(OP_SET_ROLL, 16'h0CCC, 0, ST_OK, 1, 8'hA5);
        do_push(OP_EMER_LAND, 16'h0000, 1, ST_OK, 1, 8'hA5);
        wait_done(2, 400);
        repeat (30) @(negedge clk);
        check_eq("emer_empty", empty, 1);
`endif

        repeat (5) @(negedge clk);
        check_eq("final_sb", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
